edit_controller: RTL and testbench

Sequencer between the USB keycode mapper and the pattern memory of the tracker. It edge-detects and auto-repeats the mapper's level-coded cursor and edit commands, and owns the 80×30 cursor position. It runs each edit as a read-modify-write on the shared pattern RAM, requesting access through a grant handshake because the video renderer has priority on that port.

---
 rtl/tracker_pkg.sv | 36 +++
 rtl/edit_controller_if.sv | 21 ++
 rtl/key_repeat.sv | 50 +++++
 rtl/edit_controller.sv | 138 +++++++++++++
 tb/tb_edit_controller.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tracker_pkg.sv
// Shared types and constants for the tracker's keyboard-to-pattern-RAM path.
// The command encodings mirror the USB keycode mapper's outputs.
package tracker_pkg;

    localparam int GRID_W = 80;
    localparam int GRID_H = 30;
    localparam int ADDR_W = 12;

    typedef enum logic [2:0] {
        CUR_NONE  = 3'b000,
        CUR_LEFT  = 3'b001,
        CUR_RIGHT = 3'b010,
        CUR_UP    = 3'b011,
        CUR_DOWN  = 3'b100
    } cursor_cmd_t;

    typedef enum logic [1:0] {
        EDIT_NONE = 2'b00,
        EDIT_INC  = 2'b01,
        EDIT_DEC  = 2'b10,
        EDIT_DEL  = 2'b11
    } edit_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        MOD,
        WR
    } edit_state_t;

    // Row-major cell address within the 80x30 pattern grid.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] x, input logic [4:0] y);
        return ADDR_W'(y) * ADDR_W'(GRID_W) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/edit_controller_if.sv
// Request/grant port onto the shared pattern RAM; the video renderer arbitrates it.
interface edit_controller_if #(
    parameter int DATA_W = 8
);
    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [11:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rdata
    );
endinterface

// File: rtl/key_repeat.sv
// Registers a level-coded key command and turns it into one-cycle events:
// on every change to a nonzero code, then after REPEAT_DELAY and every REPEAT_RATE cycles.
module key_repeat #(
    parameter int CODE_W       = 3,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic [CODE_W-1:0] cmd,
    output logic              key_event,
    output logic [CODE_W-1:0] code
);
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] prev_q;
    logic [24:0]       cnt_q;
    logic              repeating_q;
    logic [24:0]       limit;
    logic              held;

    assign code  = code_q;
    assign held  = (code_q != '0) && (code_q == prev_q);
    assign limit = repeating_q ? 25'(REPEAT_RATE - 1) : 25'(REPEAT_DELAY - 1);

    // The counter value is stale on the change cycle, so the change term fires there on its own.
    assign key_event = (code_q != '0) && ((code_q != prev_q) || (cnt_q == limit));

    // NOTE: non-blocking assignments keep prev_q holding the old code_q within the same edge.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            code_q      <= '0;
            prev_q      <= '0;
            cnt_q       <= '0;
            repeating_q <= 1'b0;
        end else begin
            code_q <= cmd;
            prev_q <= code_q;
            if (!held) begin
                cnt_q       <= '0;
                repeating_q <= 1'b0;
            end else if (cnt_q == limit) begin
                cnt_q       <= '0;
                repeating_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 25'd1;
            end
        end
    end

endmodule

// File: rtl/edit_controller.sv
// Cursor and edit sequencer between the keycode mapper and the shared pattern RAM.
// Edits run as read-modify-write cycles behind a request/grant handshake.
module edit_controller
    import tracker_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic [2:0]        user_cursor,
    input  logic [1:0]        user_edit,
    output logic [6:0]        cursor_x,
    output logic [4:0]        cursor_y,
    edit_controller_if.master mem,
    output logic              busy,
    output logic              edit_done
);
    logic [2:0] cursor_clean;
    logic       cur_evt;
    logic [2:0] cur_code;
    logic       edit_evt;
    logic [1:0] edit_code;

    // Reserved cursor codes behave exactly like "none", including clearing the repeat counter.
    assign cursor_clean = (user_cursor > 3'd4) ? 3'd0 : user_cursor;

    key_repeat #(.CODE_W(3), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_cursor_rep (
        .clk(clk), .Reset_n(Reset_n), .cmd(cursor_clean), .key_event(cur_evt), .code(cur_code)
    );

    key_repeat #(.CODE_W(2), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_edit_rep (
        .clk(clk), .Reset_n(Reset_n), .cmd(user_edit), .key_event(edit_evt), .code(edit_code)
    );

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cursor_x <= '0;
            cursor_y <= '0;
        end else if (cur_evt) begin
            case (cursor_cmd_t'(cur_code))
                CUR_LEFT:  cursor_x <= (cursor_x == 7'd0) ? 7'(GRID_W - 1) : cursor_x - 7'd1;
                CUR_RIGHT: cursor_x <= (cursor_x == 7'(GRID_W - 1)) ? 7'd0 : cursor_x + 7'd1;
                CUR_UP:    cursor_y <= (cursor_y == 5'd0) ? 5'(GRID_H - 1) : cursor_y - 5'd1;
                CUR_DOWN:  cursor_y <= (cursor_y == 5'(GRID_H - 1)) ? 5'd0 : cursor_y + 5'd1;
                default:   ;
            endcase
        end
    end

    edit_state_t       state_q, state_d;
    edit_cmd_t         op_q, op_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [11:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_d;
    logic              granted;

    assign granted = req_q && mem.mem_gnt;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (edit_evt) begin
                    op_d   = edit_cmd_t'(edit_code);
                    addr_d = cell_addr(cursor_x, cursor_y);
                    req_d  = 1'b1;
                    if (edit_cmd_t'(edit_code) == EDIT_DEL) begin
                        state_d = WR;
                        we_d    = 1'b1;
                        wdata_d = '0;
                    end else begin
                        state_d = RD;
                        we_d    = 1'b0;
                    end
                end
            end
            RD: begin
                if (granted) begin
                    state_d = MOD;
                    req_d   = 1'b0;
                end
            end
            MOD: begin
                wdata_d = (op_q == EDIT_INC) ? mem.mem_rdata + DATA_W'(1) : mem.mem_rdata - DATA_W'(1);
                state_d = WR;
                req_d   = 1'b1;
                we_d    = 1'b1;
            end
            WR: begin
                if (granted) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            op_q      <= EDIT_NONE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            busy      <= 1'b0;
            edit_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            busy      <= (state_d != IDLE);
            edit_done <= done_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_edit_controller.sv
// Directed bench for edit_controller: cursor wrap, read-modify-write edits,
// auto-repeat, withheld grant and reset during a write, against a behavioural RAM.
module tb_edit_controller;
    import tracker_pkg::*;

    logic       clk = 1'b0;
    logic       Reset_n;
    logic [2:0] user_cursor;
    logic [1:0] user_edit;
    logic [6:0] cursor_x;
    logic [4:0] cursor_y;
    logic       busy;
    logic       edit_done;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_model [0:2399];
    int          rd_count = 0;
    int          wr_count = 0;
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    always #5 clk = ~clk;

    edit_controller_if #(.DATA_W(8)) mem_if ();

    edit_controller #(.DATA_W(8), .REPEAT_DELAY(8), .REPEAT_RATE(3)) dut (
        .clk(clk), .Reset_n(Reset_n), .user_cursor(user_cursor), .user_edit(user_edit),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .mem(mem_if.master),
        .busy(busy), .edit_done(edit_done)
    );

    // Behavioural pattern RAM: read data lands the cycle after a granted read.
    always @(posedge clk) begin
        if (pre_we) mem_model[pre_addr] <= pre_data;
        if (mem_if.mem_req && mem_if.mem_gnt) begin
            if (mem_if.mem_we) begin
                mem_model[mem_if.mem_addr] <= mem_if.mem_wdata;
                wr_count <= wr_count + 1;
            end else begin
                mem_if.mem_rdata <= mem_model[mem_if.mem_addr];
                rd_count <= rd_count + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_cursor(input cursor_cmd_t c);
        user_cursor = c;
        tick(1);
        user_cursor = CUR_NONE;
        tick(1);
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick(1);
        pre_we   = 1'b0;
    endtask

    task automatic test_reset;
        tick(2);
        checks++; if (cursor_x !== 7'd0) begin errors++; $display("FAIL reset_x got %0d exp 0", cursor_x); end
        checks++; if (cursor_y !== 5'd0) begin errors++; $display("FAIL reset_y got %0d exp 0", cursor_y); end
        checks++; if (mem_if.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_if.mem_req); end
        checks++; if (mem_if.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", mem_if.mem_we); end
        checks++; if (mem_if.mem_addr !== 12'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", mem_if.mem_addr); end
        checks++; if (mem_if.mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h exp 00", mem_if.mem_wdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (edit_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", edit_done); end
        Reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_cursor_wrap;
        for (int i = 1; i <= 80; i++) begin
            press_cursor(CUR_RIGHT);
            checks++;
            if (cursor_x !== 7'(i % 80)) begin
                errors++; $display("FAIL right_step%0d got x=%0d exp x=%0d", i, cursor_x, i % 80);
            end
        end
        press_cursor(CUR_UP);
        checks++; if (cursor_y !== 5'd29) begin errors++; $display("FAIL up_wrap got y=%0d exp 29", cursor_y); end
        checks++; if (cursor_x !== 7'd0) begin errors++; $display("FAIL up_wrap_x got x=%0d exp 0", cursor_x); end
    endtask

    task automatic test_increment;
        int r0, w0;
        repeat (3) press_cursor(CUR_DOWN);
        repeat (5) press_cursor(CUR_RIGHT);
        checks++; if (cursor_x !== 7'd5 || cursor_y !== 5'd2) begin errors++; $display("FAIL inc_pos got (%0d,%0d) exp (5,2)", cursor_x, cursor_y); end
        preload(12'd165, 8'hFF);
        r0 = rd_count; w0 = wr_count;
        user_edit = EDIT_INC;
        tick(1);
        user_edit = EDIT_NONE;
        tick(1);
        checks++; if ({mem_if.mem_req, mem_if.mem_we, busy, edit_done} !== 4'b1010 || mem_if.mem_addr !== 12'd165) begin
            errors++; $display("FAIL inc_rd got req/we/busy/done=%b addr=%0d exp 1010 addr=165", {mem_if.mem_req, mem_if.mem_we, busy, edit_done}, mem_if.mem_addr); end
        tick(1);
        checks++; if ({mem_if.mem_req, busy, edit_done} !== 3'b010) begin
            errors++; $display("FAIL inc_mod got req/busy/done=%b exp 010", {mem_if.mem_req, busy, edit_done}); end
        tick(1);
        checks++; if ({mem_if.mem_req, mem_if.mem_we, busy, edit_done} !== 4'b1110 || mem_if.mem_addr !== 12'd165 || mem_if.mem_wdata !== 8'h00) begin
            errors++; $display("FAIL inc_wr got req/we/busy/done=%b addr=%0d wdata=%h exp 1110 addr=165 wdata=00", {mem_if.mem_req, mem_if.mem_we, busy, edit_done}, mem_if.mem_addr, mem_if.mem_wdata); end
        tick(1);
        checks++; if ({mem_if.mem_req, busy, edit_done} !== 3'b001) begin
            errors++; $display("FAIL inc_done got req/busy/done=%b exp 001", {mem_if.mem_req, busy, edit_done}); end
        tick(1);
        checks++; if ({busy, edit_done} !== 2'b00) begin
            errors++; $display("FAIL inc_after got busy/done=%b exp 00", {busy, edit_done}); end
        checks++; if (rd_count !== r0 + 1 || wr_count !== w0 + 1) begin
            errors++; $display("FAIL inc_count got rd=%0d wr=%0d exp rd=%0d wr=%0d", rd_count - r0, wr_count - w0, 1, 1); end
        checks++; if (mem_model[165] !== 8'h00) begin errors++; $display("FAIL inc_cell got %h exp 00", mem_model[165]); end
    endtask

    task automatic test_delete;
        int r0, w0;
        repeat (6) press_cursor(CUR_LEFT);
        repeat (3) press_cursor(CUR_UP);
        checks++; if (cursor_x !== 7'd79 || cursor_y !== 5'd29) begin errors++; $display("FAIL del_pos got (%0d,%0d) exp (79,29)", cursor_x, cursor_y); end
        preload(12'd2399, 8'hAB);
        r0 = rd_count; w0 = wr_count;
        user_edit = EDIT_DEL;
        tick(1);
        user_edit = EDIT_NONE;
        tick(1);
        checks++; if ({mem_if.mem_req, mem_if.mem_we, busy} !== 3'b111 || mem_if.mem_addr !== 12'd2399 || mem_if.mem_wdata !== 8'h00) begin
            errors++; $display("FAIL del_wr got req/we/busy=%b addr=%0d wdata=%h exp 111 addr=2399 wdata=00", {mem_if.mem_req, mem_if.mem_we, busy}, mem_if.mem_addr, mem_if.mem_wdata); end
        tick(1);
        checks++; if ({mem_if.mem_req, busy, edit_done} !== 3'b001) begin
            errors++; $display("FAIL del_done got req/busy/done=%b exp 001", {mem_if.mem_req, busy, edit_done}); end
        checks++; if (rd_count !== r0 || wr_count !== w0 + 1) begin
            errors++; $display("FAIL del_count got rd=%0d wr=%0d exp rd=0 wr=1", rd_count - r0, wr_count - w0); end
        checks++; if (mem_model[2399] !== 8'h00) begin errors++; $display("FAIL del_cell got %h exp 00", mem_model[2399]); end
    endtask

    task automatic test_auto_repeat;
        int ev[5] = '{0, 8, 11, 14, 17};
        int n;
        repeat (11) press_cursor(CUR_RIGHT);
        checks++; if (cursor_x !== 7'd10) begin errors++; $display("FAIL rep_start got x=%0d exp 10", cursor_x); end
        user_cursor = CUR_LEFT;
        for (int t = 1; t <= 24; t++) begin
            tick(1);
            n = 0;
            for (int k = 0; k < 5; k++) if (ev[k] <= t - 2) n++;
            checks++;
            if (cursor_x !== 7'(10 - n)) begin
                errors++; $display("FAIL rep_t%0d got x=%0d exp x=%0d", t, cursor_x, 10 - n);
            end
            if (t == 20) user_cursor = CUR_NONE;
        end
    endtask

    task automatic test_grant_stall;
        int r0, w0;
        preload(12'd2325, 8'h10);
        r0 = rd_count; w0 = wr_count;
        mem_if.mem_gnt = 1'b0;
        user_edit = EDIT_DEC;
        tick(1);
        user_edit = EDIT_NONE;
        for (int t = 2; t <= 8; t++) begin
            tick(1);
            checks++;
            if ({mem_if.mem_req, mem_if.mem_we, busy} !== 3'b101 || mem_if.mem_addr !== 12'd2325) begin
                errors++; $display("FAIL stall_t%0d got req/we/busy=%b addr=%0d exp 101 addr=2325", t, {mem_if.mem_req, mem_if.mem_we, busy}, mem_if.mem_addr);
            end
            if (t == 3) user_edit = EDIT_INC;
            if (t == 4) user_edit = EDIT_NONE;
            if (t == 8) mem_if.mem_gnt = 1'b1;
        end
        tick(1);
        checks++; if ({mem_if.mem_req, busy} !== 2'b01) begin errors++; $display("FAIL stall_mod got req/busy=%b exp 01", {mem_if.mem_req, busy}); end
        tick(1);
        checks++; if ({mem_if.mem_req, mem_if.mem_we} !== 2'b11 || mem_if.mem_wdata !== 8'h0F) begin
            errors++; $display("FAIL stall_wr got req/we=%b wdata=%h exp 11 wdata=0f", {mem_if.mem_req, mem_if.mem_we}, mem_if.mem_wdata); end
        tick(1);
        checks++; if (edit_done !== 1'b1) begin errors++; $display("FAIL stall_done got %b exp 1", edit_done); end
        tick(4);
        checks++; if (rd_count !== r0 + 1 || wr_count !== w0 + 1 || busy !== 1'b0) begin
            errors++; $display("FAIL stall_count got rd=%0d wr=%0d busy=%b exp rd=1 wr=1 busy=0", rd_count - r0, wr_count - w0, busy); end
        checks++; if (mem_model[2325] !== 8'h0F) begin errors++; $display("FAIL stall_cell got %h exp 0f", mem_model[2325]); end
    endtask

    task automatic test_same_cycle_reset;
        int w0;
        press_cursor(CUR_DOWN);
        repeat (2) press_cursor(CUR_LEFT);
        checks++; if (cursor_x !== 7'd3 || cursor_y !== 5'd0) begin errors++; $display("FAIL same_pos got (%0d,%0d) exp (3,0)", cursor_x, cursor_y); end
        preload(12'd3, 8'h41);
        w0 = wr_count;
        user_edit = EDIT_INC;
        user_cursor = CUR_RIGHT;
        tick(1);
        user_edit = EDIT_NONE;
        user_cursor = CUR_NONE;
        tick(1);
        checks++; if (mem_if.mem_addr !== 12'd3 || cursor_x !== 7'd4) begin
            errors++; $display("FAIL same_cycle got addr=%0d x=%0d exp addr=3 x=4", mem_if.mem_addr, cursor_x); end
        tick(2);
        checks++; if ({mem_if.mem_req, mem_if.mem_we} !== 2'b11 || mem_if.mem_addr !== 12'd3 || mem_if.mem_wdata !== 8'h42) begin
            errors++; $display("FAIL same_wr got req/we=%b addr=%0d wdata=%h exp 11 addr=3 wdata=42", {mem_if.mem_req, mem_if.mem_we}, mem_if.mem_addr, mem_if.mem_wdata); end
        Reset_n = 1'b0;
        #1;
        checks++; if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin errors++; $display("FAIL rst_wr_pos got (%0d,%0d) exp (0,0)", cursor_x, cursor_y); end
        checks++; if ({mem_if.mem_req, mem_if.mem_we, busy, edit_done} !== 4'b0000) begin
            errors++; $display("FAIL rst_wr_ctrl got req/we/busy/done=%b exp 0000", {mem_if.mem_req, mem_if.mem_we, busy, edit_done}); end
        checks++; if (mem_if.mem_addr !== 12'd0 || mem_if.mem_wdata !== 8'h00) begin
            errors++; $display("FAIL rst_wr_bus got addr=%0d wdata=%h exp addr=0 wdata=00", mem_if.mem_addr, mem_if.mem_wdata); end
        tick(2);
        Reset_n = 1'b1;
        tick(2);
        checks++; if (wr_count !== w0 || mem_model[3] !== 8'h41) begin
            errors++; $display("FAIL rst_no_write got writes=%0d cell=%h exp writes=0 cell=41", wr_count - w0, mem_model[3]); end
        checks++; if ({mem_if.mem_req, busy} !== 2'b00) begin errors++; $display("FAIL rst_idle got req/busy=%b exp 00", {mem_if.mem_req, busy}); end
    endtask

    initial begin
        Reset_n        = 1'b0;
        user_cursor    = CUR_NONE;
        user_edit      = EDIT_NONE;
        mem_if.mem_gnt = 1'b1;
        test_reset();
        test_cursor_wrap();
        test_increment();
        test_delete();
        test_auto_repeat();
        test_grant_stall();
        test_same_cycle_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
